// File: rtl/ddr2_cmd_sched.sv
// ddr2_cmd_sched: moves fixed-size bursts from the ingest FIFO into a DDR2
// ring buffer through the MIG user interface and issues read-back commands.
// Build option: define CMD_SCHED_RD_PRIO_EN to let reads always win
// arbitration; otherwise write and read alternate when both are eligible.
module ddr2_cmd_sched #(
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LEN    = 4,
  parameter int ADDR_WIDTH   = 31,
  parameter int ADDR_BASE    = 0,
  parameter int ADDR_STEP    = 4,
  parameter int DEPTH_BURSTS = 1024,
  parameter int LEVEL_WIDTH  = 10
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          phy_init_done,
  input  logic                          app_wdf_afull,
  input  logic                          app_af_afull,
  input  logic [LEVEL_WIDTH-1:0]        wr_fifo_count,
  input  logic                          rd_req,
  output logic                          wr_fifo_rd,
  output logic                          app_wdf_wren,
  output logic                          app_af_wren,
  output logic [2:0]                    app_af_cmd,
  output logic [ADDR_WIDTH-1:0]         app_af_addr,
  output logic                          rd_ack,
  output logic [$clog2(DEPTH_BURSTS):0] fill_bursts,
  output logic                          busy
);

  localparam int WDF_WORDS = BURST_LEN / 2;
  localparam int SLOT_W    = $clog2(DEPTH_BURSTS);
  localparam int PTR_W     = SLOT_W + 1;
  localparam int CNT_W     = $clog2(WDF_WORDS + 1);

  typedef enum logic [2:0] {IDLE, ARB, WR_DATA, WR_CMD, RD_CMD} state_t;

  state_t                 state, state_nx;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, fill_int;
  logic [CNT_W-1:0]       word_cnt, word_cnt_nx;
  logic                   last_was_wr, last_was_wr_nx;
  logic                   wr_elig, rd_elig, grant_wr, grant_rd;
  logic                   fifo_rd_nx, af_wren_nx, rd_ack_nx;
  logic [2:0]             af_cmd_nx;
  logic [ADDR_WIDTH-1:0]  af_addr_nx;

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [SLOT_W-1:0] slot);
    logic [63:0] full;
    full = 64'(ADDR_BASE) + 64'(slot) * 64'(ADDR_STEP);
    return full[ADDR_WIDTH-1:0];
  endfunction

  // Live pointer difference drives eligibility; the fill_bursts port is its registered copy.
  assign fill_int = wr_ptr - rd_ptr;
  assign wr_elig  = (wr_fifo_count >= LEVEL_WIDTH'(WDF_WORDS)) &&
                    (fill_int < PTR_W'(DEPTH_BURSTS)) && phy_init_done;
  assign rd_elig  = rd_req && (fill_int != '0) && phy_init_done;

  // Arbitration between the two eligible requesters.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
`ifdef CMD_SCHED_RD_PRIO_EN
    grant_rd = rd_elig;
`else
    grant_rd = rd_elig && (!wr_elig || last_was_wr);
`endif
    grant_wr = wr_elig && !grant_rd;
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nx       = state;
    word_cnt_nx    = word_cnt;
    last_was_wr_nx = last_was_wr;
    wr_ptr_nx      = wr_ptr;
    rd_ptr_nx      = rd_ptr;
    fifo_rd_nx     = 1'b0;
    af_wren_nx     = 1'b0;
    rd_ack_nx      = 1'b0;
    af_cmd_nx      = app_af_cmd;
    af_addr_nx     = app_af_addr;
    case (state)
      IDLE: begin
        if (phy_init_done) state_nx = ARB;
      end
      ARB: begin
        if (grant_rd) begin
          state_nx       = RD_CMD;
          last_was_wr_nx = 1'b0;
        end else if (grant_wr) begin
          state_nx       = WR_DATA;
          last_was_wr_nx = 1'b1;
          word_cnt_nx    = '0;
        end else if (!phy_init_done) begin
          state_nx = IDLE;
        end
      end
      WR_DATA: begin
        if (!app_wdf_afull) begin
          fifo_rd_nx = 1'b1;
          if (word_cnt == CNT_W'(WDF_WORDS - 1)) begin
            word_cnt_nx = '0;
            state_nx    = WR_CMD;
          end else begin
            word_cnt_nx = word_cnt + CNT_W'(1);
          end
        end
      end
      WR_CMD: begin
        if (!app_af_afull) begin
          af_wren_nx = 1'b1;
          af_cmd_nx  = 3'b000;
          af_addr_nx = slot_addr(wr_ptr[SLOT_W-1:0]);
          wr_ptr_nx  = wr_ptr + PTR_W'(1);
          state_nx   = ARB;
        end
      end
      RD_CMD: begin
        if (!app_af_afull) begin
          af_wren_nx = 1'b1;
          rd_ack_nx  = 1'b1;
          af_cmd_nx  = 3'b001;
          af_addr_nx = slot_addr(rd_ptr[SLOT_W-1:0]);
          rd_ptr_nx  = rd_ptr + PTR_W'(1);
          state_nx   = ARB;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers: pointers, burst word counter and all output strobes.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      word_cnt     <= '0;
      last_was_wr  <= 1'b1;
      wr_fifo_rd   <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_af_wren  <= 1'b0;
      app_af_cmd   <= '0;
      app_af_addr  <= ADDR_WIDTH'(ADDR_BASE);
      rd_ack       <= 1'b0;
      fill_bursts  <= '0;
      busy         <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nx;
      rd_ptr       <= rd_ptr_nx;
      word_cnt     <= word_cnt_nx;
      last_was_wr  <= last_was_wr_nx;
      wr_fifo_rd   <= fifo_rd_nx;
      app_wdf_wren <= wr_fifo_rd;
      app_af_wren  <= af_wren_nx;
      app_af_cmd   <= af_cmd_nx;
      app_af_addr  <= af_addr_nx;
      rd_ack       <= rd_ack_nx;
      fill_bursts  <= fill_int;
      busy         <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_ddr2_cmd_sched.sv
// Bench for ddr2_cmd_sched with a 4-burst ring: directed scenarios followed by
// randomized traffic, checked against a transaction-level ring model.
module tb_ddr2_cmd_sched;

  localparam int DEPTH = 4;
  localparam int STEP  = 4;
  localparam int BASE  = 0;
  localparam int WDF   = 2;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1, phy_init_done = 1'b0, app_wdf_afull = 1'b0;
  logic        app_af_afull = 1'b0, rd_req = 1'b0;
  logic [9:0]  wr_fifo_count;
  logic        wr_fifo_rd, app_wdf_wren, app_af_wren, rd_ack, busy;
  logic [2:0]  app_af_cmd;
  logic [30:0] app_af_addr;
  logic [2:0]  fill_bursts;

  bit fifo_fixed = 1'b0;
  int fifo_added = 0, rd_total = 0;
  int n_pass = 0, n_fail = 0, cyc = 0;
  int m_fill = 0, m_wr = 0, m_rd = 0, m_words = 0, vis_fill = 0;
  logic prev_rd = 1'b0;
  int rd_cyc[$], log_cmd[$], log_addr[$], log_cyc[$];
  int exp_cmd[5], exp_addr[5];
  int b, k;

  assign wr_fifo_count = fifo_fixed ? 10'd1000 : 10'(fifo_added - rd_total);

  ddr2_cmd_sched #(
    .DATA_WIDTH(64), .BURST_LEN(4), .ADDR_WIDTH(31), .ADDR_BASE(BASE),
    .ADDR_STEP(STEP), .DEPTH_BURSTS(DEPTH), .LEVEL_WIDTH(10)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .phy_init_done(phy_init_done),
    .app_wdf_afull(app_wdf_afull), .app_af_afull(app_af_afull),
    .wr_fifo_count(wr_fifo_count), .rd_req(rd_req),
    .wr_fifo_rd(wr_fifo_rd), .app_wdf_wren(app_wdf_wren),
    .app_af_wren(app_af_wren), .app_af_cmd(app_af_cmd),
    .app_af_addr(app_af_addr), .rd_ack(rd_ack),
    .fill_bursts(fill_bursts), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] slot_addr(input int n);
    return 64'(BASE + (n % DEPTH) * STEP);
  endfunction

  // Advance to the next falling edge and update the ring model. Input values
  // held at this point are the ones the DUT sampled on the preceding rising edge.
  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    if (reset) begin
      m_fill = 0; m_wr = 0; m_rd = 0; m_words = 0; vis_fill = 0; prev_rd = 1'b0;
    end else begin
      check("wdf_wren_lag", 64'(app_wdf_wren), 64'(prev_rd));
      check("fill_track", 64'(fill_bursts), 64'(vis_fill));
      if (app_wdf_wren) m_words++;
      if (wr_fifo_rd) begin
        rd_total++;
        rd_cyc.push_back(cyc);
        check("rd_during_wdf_afull", 64'(app_wdf_afull), 64'(0));
      end
      if (app_af_wren) begin
        check("cmd_during_af_afull", 64'(app_af_afull), 64'(0));
        log_cmd.push_back(int'(app_af_cmd));
        log_addr.push_back(int'(app_af_addr));
        log_cyc.push_back(cyc);
        if (app_af_cmd == 3'b000) begin
          check("wr_addr", 64'(app_af_addr), slot_addr(m_wr));
          check("wr_words", 64'(m_words), 64'(WDF));
          check("wr_no_overflow", 64'(m_fill < DEPTH), 64'(1));
          check("wr_no_ack", 64'(rd_ack), 64'(0));
          m_wr++; m_fill++; m_words = 0;
        end else begin
          check("rd_cmd_code", 64'(app_af_cmd), 64'(1));
          check("rd_ack_with_cmd", 64'(rd_ack), 64'(1));
          check("rd_addr", 64'(app_af_addr), slot_addr(m_rd));
          check("rd_no_underflow", 64'(m_fill > 0), 64'(1));
          m_rd++; m_fill--;
        end
      end else begin
        check("ack_without_cmd", 64'(rd_ack), 64'(0));
      end
      vis_fill = m_fill;
      prev_rd = wr_fifo_rd;
    end
    #1;
  endtask

  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    while (wr_fifo_rd !== 1'b1 && n < 200) begin tick(); n++; end
    check(tag, 64'(wr_fifo_rd), 64'(1));
  endtask

  task automatic wait_cmd(input string tag);
    int n;
    n = 0;
    while (app_af_wren !== 1'b1 && n < 200) begin tick(); n++; end
    check(tag, 64'(app_af_wren), 64'(1));
  endtask

  task automatic wait_fill(input string tag, input int v);
    int n;
    n = 0;
    while (int'(fill_bursts) != v && n < 300) begin tick(); n++; end
    check(tag, 64'(fill_bursts), 64'(v));
  endtask

  initial begin
`ifdef CMD_SCHED_RD_PRIO_EN
    exp_cmd  = '{1, 1, 1, 1, 0};
    exp_addr = '{0, 4, 8, 12, 0};
`else
    exp_cmd  = '{1, 0, 1, 0, 1};
    exp_addr = '{0, 0, 4, 4, 8};
`endif
    // Reset and idle outputs.
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_wr_fifo_rd", 64'(wr_fifo_rd), 64'(0));
    check("rst_wdf_wren", 64'(app_wdf_wren), 64'(0));
    check("rst_af_wren", 64'(app_af_wren), 64'(0));
    check("rst_cmd", 64'(app_af_cmd), 64'(0));
    check("rst_addr", 64'(app_af_addr), 64'(BASE));
    check("rst_rd_ack", 64'(rd_ack), 64'(0));
    check("rst_fill", 64'(fill_bursts), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // First write burst once calibration completes.
    repeat (3) tick();
    phy_init_done = 1'b1;
    fifo_added = 2;
    b = rd_cyc.size();
    wait_rd("w1_first_rd");
    tick();
    check("w1_second_rd", 64'(wr_fifo_rd), 64'(1));
    wait_cmd("w1_cmd");
    check("w1_cmd_code", 64'(app_af_cmd), 64'(0));
    check("w1_addr", 64'(app_af_addr), 64'(0));
    check("w1_two_reads", 64'(rd_cyc.size() - b), 64'(2));
    check("w1_cmd_latency", 64'(log_cyc[log_cyc.size()-1] - rd_cyc[b]), 64'(2));
    tick();
    check("w1_fill", 64'(fill_bursts), 64'(1));

    // Write-data stall of three cycles between the two words.
    fifo_added += 2;
    b = rd_cyc.size();
    wait_rd("w2_first_rd");
    app_wdf_afull = 1'b1;
    tick(); check("w2_gap1", 64'(wr_fifo_rd), 64'(0));
    tick(); check("w2_gap2", 64'(wr_fifo_rd), 64'(0));
    tick(); check("w2_gap3", 64'(wr_fifo_rd), 64'(0));
    app_wdf_afull = 1'b0;
    tick(); check("w2_second_rd", 64'(wr_fifo_rd), 64'(1));
    wait_cmd("w2_cmd");
    check("w2_addr", 64'(app_af_addr), 64'(4));
    check("w2_two_reads", 64'(rd_cyc.size() - b), 64'(2));
    check("w2_cmd_latency", 64'(log_cyc[log_cyc.size()-1] - rd_cyc[b]), 64'(5));

    // Fill the ring; no further FIFO reads once it holds DEPTH bursts.
    fifo_fixed = 1'b1;
    wait_fill("ring_full", DEPTH);
    check("fill_addr3", 64'(log_addr[log_addr.size()-2]), 64'(8));
    check("fill_addr4", 64'(log_addr[log_addr.size()-1]), 64'(12));
    b = rd_cyc.size();
    repeat (20) tick();
    check("full_no_rd", 64'(rd_cyc.size() - b), 64'(0));
    check("full_fill_held", 64'(fill_bursts), 64'(DEPTH));
    check("full_busy", 64'(busy), 64'(1));

    // Both requesters eligible: arbitration order and ring wrap.
    b = log_cmd.size();
    rd_req = 1'b1;
    k = 0;
    while (log_cmd.size() < b + 5 && k < 200) begin tick(); k++; end
    check("arb_cmd_count", 64'(log_cmd.size() >= b + 5), 64'(1));
    if (log_cmd.size() >= b + 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("arb_cmd%0d", i), 64'(log_cmd[b+i]), 64'(exp_cmd[i]));
        check($sformatf("arb_addr%0d", i), 64'(log_addr[b+i]), 64'(exp_addr[i]));
      end
    end

    // Randomized traffic with back-pressure.
    fifo_fixed = 1'b0;
    fifo_added = rd_total + 6;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) rd_req = ~rd_req;
      app_wdf_afull = ($urandom_range(0, 3) == 0);
      app_af_afull  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0 && (fifo_added - rd_total) < 500)
        fifo_added += $urandom_range(1, 3);
      tick();
    end

    // Drain the ring, then drop calibration in the middle of a burst.
    app_wdf_afull = 1'b0;
    app_af_afull  = 1'b0;
    fifo_added = rd_total + 2;
    rd_req = 1'b1;
    repeat (10) tick();
    wait_fill("drain_empty", 0);
    rd_req = 1'b0;
    repeat (3) tick();
    fifo_added += 2;
    wait_rd("phy_drop_rd");
    phy_init_done = 1'b0;
    wait_cmd("phy_drop_cmd");
    check("phy_drop_cmd_code", 64'(app_af_cmd), 64'(0));
    b = rd_cyc.size();
    fifo_added += 4;
    repeat (6) tick();
    check("phy_drop_idle", 64'(busy), 64'(0));
    check("phy_drop_no_rd", 64'(rd_cyc.size() - b), 64'(0));

    // Reset while a burst is in WR_DATA.
    phy_init_done = 1'b1;
    wait_rd("rst_mid_rd");
    reset = 1'b1;
    tick();
    check("rstm_wr_fifo_rd", 64'(wr_fifo_rd), 64'(0));
    check("rstm_wdf_wren", 64'(app_wdf_wren), 64'(0));
    check("rstm_af_wren", 64'(app_af_wren), 64'(0));
    check("rstm_cmd", 64'(app_af_cmd), 64'(0));
    check("rstm_addr", 64'(app_af_addr), 64'(BASE));
    check("rstm_rd_ack", 64'(rd_ack), 64'(0));
    check("rstm_fill", 64'(fill_bursts), 64'(0));
    check("rstm_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    wait_cmd("post_rst_cmd");
    check("post_rst_addr", 64'(app_af_addr), 64'(BASE));
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/ddr2_cmd_sched.md
# ddr2_cmd_sched

Parametrised DDR2 command scheduler between the ingest write FIFO and the Virtex-5 MIG user interface. It moves fixed-size bursts from the FIFO into DDR2 as a circular buffer of `DEPTH_BURSTS` bursts, and issues read-back commands on request. A fill count of written-but-unread bursts replaces the external address-conflict flag. Arbitration between write and read is round-robin, with an optional read-priority mode.

## Interface
- `DATA_WIDTH`, 64: FIFO/app_wdf word width. Informational; no data passes through this block.
- `BURST_LEN`, 4: DDR2 burst length. The block moves `WDF_WORDS = BURST_LEN/2` FIFO words per burst.
- `ADDR_WIDTH`, 31: width of app_af_addr.
- `ADDR_BASE`, 0: DDR2 address of ring slot 0.
- `ADDR_STEP`, 4: address increment per burst.
- `DEPTH_BURSTS`, 1024: ring size in bursts. Must be a power of two, ≥2.
- `LEVEL_WIDTH`, 10: width of wr_fifo_count.
- `sys_clk` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `phy_init_done` in 1: MIG calibration complete.
- `app_wdf_afull` in 1: MIG write-data FIFO almost full.
- `app_af_afull` in 1: MIG address FIFO almost full.
- `wr_fifo_count` in LEVEL_WIDTH: words held in the ingest FIFO.
- `rd_req` in 1: level request for one read burst.
- `wr_fifo_rd` out 1: read strobe to the ingest FIFO. FIFO data appears 1 cycle later.
- `app_wdf_wren` out 1: wr_fifo_rd delayed by 1 cycle.
- `app_af_wren` out 1: address/command write strobe.
- `app_af_cmd` out 3: 3'b000 = write, 3'b001 = read.
- `app_af_addr` out ADDR_WIDTH: `ADDR_BASE + slot*ADDR_STEP`, truncated to ADDR_WIDTH.
- `rd_ack` out 1: 1-cycle pulse on the cycle a read command is issued.
- `fill_bursts` out clog2(DEPTH_BURSTS)+1: number of written, unread bursts.
- `busy` out 1: high in every state except IDLE.

## Operation
- Pointers: `wr_ptr` and `rd_ptr`, each clog2(DEPTH_BURSTS)+1 bits, free-running with natural wrap.
  - `fill_bursts = wr_ptr - rd_ptr`, modulo 2^(width).
  - Slot index = pointer low clog2(DEPTH_BURSTS) bits. Slot DEPTH_BURSTS-1 is followed by slot 0.
- Write-eligible when all hold: `wr_fifo_count >= WDF_WORDS`, `fill_bursts < DEPTH_BURSTS`, `phy_init_done`.
- Read-eligible when all hold: `rd_req`, `fill_bursts != 0`, `phy_init_done`.
- FSM states:
  - IDLE: go to ARB when `phy_init_done`.
  - ARB: if both requesters are eligible, grant the one not granted last (`last_was_wr` flag, reset value 1, so a read wins first). If only one is eligible, grant it. If neither and `!phy_init_done`, go to IDLE. Otherwise stay.
  - WR_DATA: assert wr_fifo_rd on each cycle `!app_wdf_afull`, counting to WDF_WORDS. When app_wdf_afull is high, wr_fifo_rd is low and the count holds. After the last word, go to WR_CMD.
  - WR_CMD: when `!app_af_afull`, assert app_af_wren with cmd 000 and the wr_ptr slot address, increment wr_ptr, go to ARB. Otherwise wait.
  - RD_CMD: when `!app_af_afull`, assert app_af_wren with cmd 001, the rd_ptr slot address, and rd_ack; increment rd_ptr, go to ARB. Otherwise wait.
- All outputs are registered. Reset values: state IDLE, both pointers 0, all strobes 0, app_af_cmd 0, app_af_addr = ADDR_BASE, fill_bursts 0, busy 0.
- `phy_init_done` falling mid-burst: the current burst (data and command) completes, then the FSM returns to IDLE via ARB.
- `reset` mid-burst: the FSM aborts immediately to reset values. Partial FIFO reads are not recovered.
- Simultaneous write command and read grant are impossible, since there is one command port. fill_bursts changes by at most ±1 per cycle.

## Timing
- Write burst without stalls: 1 ARB + WDF_WORDS WR_DATA + 1 WR_CMD = WDF_WORDS+2 cycles.
- app_wdf_wren lags wr_fifo_rd by exactly 1 cycle. The last data word reaches MIG on the same cycle as the write command.
- Read: 1 ARB + 1 RD_CMD = 2 cycles. rd_ack and app_af_wren are coincident.
- fill_bursts updates on the cycle after the app_af_wren strobe.
- Each wait on app_af_afull or app_wdf_afull adds one cycle per cycle it is high. Strobes are held low during waits.

## Configuration
- `CMD_SCHED_RD_PRIO_EN` defined: in ARB, a read-eligible request always wins over a write-eligible one. last_was_wr is ignored.
- Not defined: round-robin arbitration as described above.

## Test plan
- Reset release, then phy_init_done=1 at cycle 5 and wr_fifo_count=2 (BURST_LEN 4) -> wr_fifo_rd high on 2 consecutive cycles, app_af_wren with cmd 000 and addr 0, then fill_bursts=1.
- Stall: app_wdf_afull high for 3 cycles during WR_DATA -> wr_fifo_rd gaps for 3 cycles, still exactly 2 reads, burst total 7 cycles.
- DEPTH_BURSTS=4, rd_req=0, FIFO always full -> 4 writes at addr 0, 4, 8, 12; then no further wr_fifo_rd; fill_bursts=4.
- Wrap: then hold rd_req=1 -> reads at 0, 4, 8, 12 interleaved with writes; the next write goes to addr 0; fill_bursts never exceeds 4 or underflows.
- Both eligible continuously -> commands alternate R, W, R, W. With CMD_SCHED_RD_PRIO_EN, only reads until fill_bursts=0.
- reset asserted during WR_DATA -> the next cycle all outputs are 0, fill_bursts=0, state IDLE.
